// File: rtl/crt_recombine_if.sv
// Handshake and operand bundle for the CRT recombination stage.
// The requester drives start and operands; the stage returns m/done/busy/err.
interface crt_recombine_if #(
    parameter int W = 512
);
    logic           start;
    logic [W-1:0]   p;
    logic [W-1:0]   q;
    logic [W-1:0]   qinv;
    logic [W-1:0]   m1;
    logic [W-1:0]   m2;
    logic [2*W-1:0] m;
    logic           done;
    logic           busy;
    logic           err;

    modport master (
        output start, p, q, qinv, m1, m2,
        input  m, done, busy, err
    );

    modport slave (
        input  start, p, q, qinv, m1, m2,
        output m, done, busy, err
    );
endinterface

// File: rtl/crt_recombine.sv
// CRT recombination m = m2 + q*((qinv*(m1-m2)) mod p).
// Bit-serial interleaved modular multiply followed by a shift-add multiply.
module crt_recombine #(
    parameter int W = 512
) (
    input  logic            clk,
    input  logic            rst,
    crt_recombine_if.slave  bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MODMUL,
        MUL,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [W-1:0]   rp, rq, rqinv, rm1, rm2;
    logic [W-1:0]   diff;
    logic [W+1:0]   acc;
    logic [2*W-1:0] prod;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] m_q;
    logic           done_q, busy_q, err_q;

    logic           bad;
    logic [W-1:0]   diff_c;
    logic [W+1:0]   pp, t0, t1, t2;
    logic [2*W-1:0] prod_c;

    assign bus.m    = m_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
    assign bus.err  = err_q;

    // Operand validation and modular difference, evaluated in CHECK
    always_comb begin
        bad    = (rm1 >= rp) || (rm2 >= rq) || (rqinv >= rp) || (rq >= rp);
        diff_c = rm1 - rm2 + ((rm1 < rm2) ? rp : '0);
    end

    // One step of interleaved modmul: double, add, reduce twice (result < p)
    always_comb begin
        pp = {2'b00, rp};
        t0 = (acc << 1) + (diff[W-1] ? {2'b00, rqinv} : '0);
        t1 = (t0 >= pp) ? t0 - pp : t0;
        t2 = (t1 >= pp) ? t1 - pp : t1;
    end

    // One MSB-first shift-add step of h*q
    always_comb begin
        prod_c = (prod << 1) + (diff[W-1] ? {{W{1'b0}}, rq} : '0);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = CHECK;
            CHECK:   state_nx = bad ? DONE : MODMUL;
            MODMUL:  if (cnt == '0) state_nx = MUL;
            MUL:     if (cnt == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp     <= '0;
            rq     <= '0;
            rqinv  <= '0;
            rm1    <= '0;
            rm2    <= '0;
            diff   <= '0;
            acc    <= '0;
            prod   <= '0;
            cnt    <= '0;
            m_q    <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        rp     <= bus.p;
                        rq     <= bus.q;
                        rqinv  <= bus.qinv;
                        rm1    <= bus.m1;
                        rm2    <= bus.m2;
                        busy_q <= 1'b1;
                        err_q  <= 1'b0;
                    end
                end
                CHECK: begin
                    if (bad) begin
                        err_q <= 1'b1;
                    end else begin
                        diff <= diff_c;
                        acc  <= '0;
                        cnt  <= CW'(W - 1);
                    end
                end
                MODMUL: begin
                    acc <= t2;
                    if (cnt == '0) begin
                        // h is reused as the multiplier bit stream for MUL
                        diff <= t2[W-1:0];
                        prod <= '0;
                        cnt  <= CW'(W - 1);
                    end else begin
                        diff <= diff << 1;
                        cnt  <= cnt - 1'b1;
                    end
                end
                MUL: begin
                    prod <= prod_c;
                    diff <= diff << 1;
                    cnt  <= cnt - 1'b1;
                end
                DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    m_q    <= err_q ? '0 : prod + {{W{1'b0}}, rm2};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_crt_recombine.sv
// Scoreboard bench for crt_recombine at W=8.
// Expected results come from direct modular arithmetic on small primes.
module tb_crt_recombine;
    localparam int W   = 8;
    localparam int LAT = 2 * W + 2;

    typedef struct {
        longint m;
        longint err;
        int     at;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   nchk;
    int   nfail;
    exp_t sb[$];

    crt_recombine_if #(.W(W)) bus ();

    crt_recombine #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int primes[$] = '{251, 241, 239, 233, 229, 227, 223, 211, 199, 197,
                      193, 191, 181, 179, 173, 167, 163, 157, 151, 149,
                      139, 137, 131, 127, 113, 109, 107, 103, 101, 97,
                      89, 83, 79, 73, 71, 67, 61, 59, 53, 47, 43, 41,
                      37, 31, 29, 23, 19, 17, 13, 11, 7, 5, 3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic void chk(string nm, longint act, longint exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endfunction

    function automatic exp_t model(longint p, longint q, longint qi,
                                   longint a, longint b, int now);
        exp_t e;
        longint d, h;
        if (a >= p || b >= q || qi >= p || q >= p) begin
            e.m   = 0;
            e.err = 1;
            e.at  = now + 1 + 2;
        end else begin
            d     = (a - b + p) % p;
            h     = (qi * d) % p;
            e.m   = b + q * h;
            e.err = 0;
            e.at  = now + 1 + LAT;
        end
        return e;
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("m", longint'(bus.m), e.m);
                chk("err", longint'(bus.err), e.err);
                chk("done_cycle", cyc, e.at);
                chk("busy_at_done", longint'(bus.busy), 0);
            end
        end
    end

    task automatic scramble();
        bus.p    = W'($urandom);
        bus.q    = W'($urandom);
        bus.qinv = W'($urandom);
        bus.m1   = W'($urandom);
        bus.m2   = W'($urandom);
    endtask

    // Issue one request at the current negedge and queue its expectation
    task automatic issue(int p, int q, int qi, int a, int b);
        bus.p     = W'(p);
        bus.q     = W'(q);
        bus.qinv  = W'(qi);
        bus.m1    = W'(a);
        bus.m2    = W'(b);
        bus.start = 1'b1;
        sb.push_back(model(p, q, qi, a, b, cyc));
        @(negedge clk);
        bus.start = 1'b0;
        scramble();
        chk("busy_after_start", longint'(bus.busy), 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4 * LAT; i++) begin
            if (bus.done) return;
            @(negedge clk);
        end
        chk("done_timeout", 0, 1);
    endtask

    function automatic int find_qinv(int p, int q);
        for (int x = 0; x < p; x++)
            if ((x * q) % p == 1) return x;
        return 0;
    endfunction

    task automatic random_run();
        int i, j, p, q, qi, a, b;
        i = $urandom_range(primes.size() - 1);
        do j = $urandom_range(primes.size() - 1); while (j == i);
        p  = (primes[i] > primes[j]) ? primes[i] : primes[j];
        q  = (primes[i] > primes[j]) ? primes[j] : primes[i];
        qi = find_qinv(p, q);
        a  = $urandom_range(p - 1);
        b  = $urandom_range(q - 1);
        if ($urandom_range(9) == 0) begin
            a  = $urandom_range(255);
            b  = $urandom_range(255);
            qi = $urandom_range(255);
        end
        issue(p, q, qi, a, b);
        wait_done();
    endtask

    initial begin
        nchk      = 0;
        nfail     = 0;
        cyc       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.p     = '0;
        bus.q     = '0;
        bus.qinv  = '0;
        bus.m1    = '0;
        bus.m2    = '0;
        repeat (2) @(negedge clk);
        chk("rst_m", longint'(bus.m), 0);
        chk("rst_done", longint'(bus.done), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_err", longint'(bus.err), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        issue(61, 53, 38, 4, 12);   wait_done();
        issue(61, 53, 38, 60, 52);  wait_done();
        issue(61, 53, 38, 5, 5);    wait_done();
        issue(61, 53, 38, 0, 0);    wait_done();
        issue(61, 53, 0, 17, 40);   wait_done();
        issue(53, 61, 38, 4, 12);   wait_done();
        issue(61, 53, 38, 61, 12);  wait_done();
        issue(61, 53, 61, 4, 12);   wait_done();
        issue(61, 53, 38, 4, 53);   wait_done();

        // Starts during a run are ignored
        issue(61, 53, 38, 60, 52);
        repeat (2) @(negedge clk);
        scramble();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        scramble();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        @(negedge clk);
        chk("no_second_done", longint'(bus.done), 0);
        chk("m_held", longint'(bus.m), 3232);

        // Reset mid-operation clears outputs and cancels the run
        issue(61, 53, 38, 4, 12);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_m", longint'(bus.m), 0);
        chk("midrst_done", longint'(bus.done), 0);
        chk("midrst_busy", longint'(bus.busy), 0);
        chk("midrst_err", longint'(bus.err), 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 5) @(negedge clk);
        issue(61, 53, 38, 4, 12);
        wait_done();

        // Back-to-back randomized runs
        for (int k = 0; k < 40; k++) random_run();

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end
endmodule
